// File: rtl/ks_arb_pkg.sv
// Shared constants and types for the round-robin arbitrated Kogge-Stone adder.
package ks_arb_pkg;

    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAdd  = 2'd1,
        StResp = 2'd2
    } state_e;

    localparam state_e            RST_STATE = StIdle;
    localparam logic [DATA_W-1:0] RST_DATA  = '0;
    localparam logic              RST_BIT   = 1'b0;

endpackage

// File: rtl/KS_Adder_16bit.sv
// 16-bit Kogge-Stone parallel-prefix adder with carry-in; purely combinational.
module KS_Adder_16bit
    import ks_arb_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              cin_i,
    output logic [DATA_W-1:0] sum_o,
    output logic              cout_o
);

    localparam int unsigned LEVELS = $clog2(DATA_W);

    logic [DATA_W-1:0] p0;
    logic [DATA_W-1:0] g_lv [LEVELS+1];
    logic [DATA_W-1:0] p_lv [LEVELS];

    assign p0 = a_i ^ b_i;
    // Carry-in folded into bit 0 so every prefix G[i] is the carry out of bit i.
    assign g_lv[0] = (a_i & b_i) | {{(DATA_W-1){1'b0}}, p0[0] & cin_i};
    assign p_lv[0] = p0;

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int unsigned D = 1 << l;
        localparam logic [DATA_W-1:0] LOW_ONES = DATA_W'((32'd1 << D) - 32'd1);

        assign g_lv[l+1] = g_lv[l] | (p_lv[l] & (g_lv[l] << D));
        if (l + 1 < LEVELS) begin : g_prop
            assign p_lv[l+1] = p_lv[l] & ((p_lv[l] << D) | LOW_ONES);
        end
    end

    assign sum_o  = p0 ^ {g_lv[LEVELS][DATA_W-2:0], cin_i};
    assign cout_o = g_lv[LEVELS][DATA_W-1];

endmodule

// File: rtl/ks_adder_arbiter.sv
// N_REQ requesters share one Kogge-Stone adder, one operation in flight (IDLE/ADD/RESP).
// Define KS_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module ks_adder_arbiter
    import ks_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [DATA_W*N_REQ-1:0]  req_a,
    input  logic [DATA_W*N_REQ-1:0]  req_b,
    input  logic [N_REQ-1:0]         req_cin,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [DATA_W-1:0]        rsp_sum,
    output logic                     rsp_cout
);

    state_e            state_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              cin_q;
    logic [ID_W-1:0]   id_q;
    logic              rsp_valid_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic [DATA_W-1:0] rsp_sum_q;
    logic              rsp_cout_q;

    logic [DATA_W-1:0] add_sum;
    logic              add_cout;
    logic [ID_W-1:0]   arb_start;
    logic              win_found;
    logic [ID_W-1:0]   win_idx;

`ifdef KS_ARB_FIXED_PRIO_EN
    assign arb_start = '0;
`else
    logic [ID_W-1:0] rr_ptr_q;
    assign arb_start = rr_ptr_q;
`endif

    always_comb begin
        logic [ID_W-1:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = ID_W'((32'(arb_start) + k) % N_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && state_q == StIdle && win_found) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    KS_Adder_16bit u_adder (
        .a_i    (a_q),
        .b_i    (b_q),
        .cin_i  (cin_q),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_STATE;
            a_q         <= RST_DATA;
            b_q         <= RST_DATA;
            cin_q       <= RST_BIT;
            id_q        <= '0;
            rsp_valid_q <= RST_BIT;
            rsp_id_q    <= '0;
            rsp_sum_q   <= RST_DATA;
            rsp_cout_q  <= RST_BIT;
`ifndef KS_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (win_found) begin
                        a_q     <= req_a[32'(win_idx)*DATA_W +: DATA_W];
                        b_q     <= req_b[32'(win_idx)*DATA_W +: DATA_W];
                        cin_q   <= req_cin[win_idx];
                        id_q    <= win_idx;
                        state_q <= StAdd;
                    end
                end
                StAdd: begin
                    rsp_sum_q   <= add_sum;
                    rsp_cout_q  <= add_cout;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
`ifndef KS_ARB_FIXED_PRIO_EN
                        rr_ptr_q    <= ID_W'((32'(id_q) + 32'd1) % N_REQ);
`endif
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;

endmodule

// File: tb/tb_ks_adder_arbiter.sv
// Directed bench for ks_adder_arbiter with a result scoreboard and immediate assertions.
module tb_ks_adder_arbiter;

    localparam int unsigned N = 4;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] sum;
        logic        cout;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [16*N-1:0] req_a;
    logic [16*N-1:0] req_b;
    logic [N-1:0]  req_cin;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    logic [15:0]   rsp_sum;
    logic          rsp_cout;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    ks_adder_arbiter #(.N_REQ(4), .ID_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic load(input int unsigned r, input logic [15:0] a, input logic [15:0] b,
                        input logic c);
        req_a[r*16 +: 16] = a;
        req_b[r*16 +: 16] = b;
        req_cin[r]        = c;
    endtask

    function automatic exp_t model(input int unsigned r);
        logic [16:0] s;
        s = {1'b0, req_a[r*16 +: 16]} + {1'b0, req_b[r*16 +: 16]} + 17'(req_cin[r]);
        return '{id: 2'(r), sum: s[15:0], cout: s[16]};
    endfunction

    task automatic check_rsp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_id"}, 32'(rsp_id), 32'(e.id));
            chk({tag, "_sum"}, 32'(rsp_sum), 32'(e.sum));
            chk({tag, "_cout"}, 32'(rsp_cout), 32'(e.cout));
        end
    endtask

    // Called in IDLE at posedge+1 with operands loaded and rsp_ready high.
    task automatic run_op(input logic [N-1:0] vmask, input int unsigned exp_id, input string tag);
        int cnt;
        req_valid = vmask;
        #1;
        chk({tag, "_grant"}, 32'(req_ready), 32'd1 << exp_id);
        sb.push_back(model(exp_id));
        step();
        req_a[exp_id*16 +: 16] = ~req_a[exp_id*16 +: 16];
        req_b[exp_id*16 +: 16] = req_b[exp_id*16 +: 16] ^ 16'h5A5A;
        req_cin[exp_id]        = ~req_cin[exp_id];
        #1;
        chk({tag, "_ready_add"}, 32'(req_ready), 32'd0);
        chk({tag, "_valid_add"}, 32'(rsp_valid), 32'd0);
        cnt = 0;
        while (!rsp_valid && cnt < 8) begin
            step();
            cnt++;
        end
        chk({tag, "_latency"}, 32'(cnt), 32'd1);
        check_rsp(tag);
        req_valid = '0;
        step();
        chk({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        exp_t e;
        int unsigned exp_g;
        rst_n     = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        rsp_ready = 1'b1;
        #12;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_sum", 32'(rsp_sum), 32'd0);
        chk("rst_cout", 32'(rsp_cout), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        step();
        rst_n = 1'b1;
        step();

        load(0, 16'h1234, 16'h5678, 1'b0);
        run_op(4'b0001, 0, "single");

        load(2, 16'hFFFF, 16'hFFFF, 1'b1);
        run_op(4'b0100, 2, "ovf1");
        load(2, 16'hFFFF, 16'h0001, 1'b0);
        run_op(4'b0100, 2, "ovf2");

        // Backpressure: response held for 10 cycles while req 1 keeps asking.
        load(1, 16'h0F0F, 16'h1234, 1'b0);
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        #1;
        chk("bp_grant", 32'(req_ready), 32'b0010);
        sb.push_back(model(1));
        step();
        step();
        chk("bp_valid", 32'(rsp_valid), 32'd1);
        e = sb.size() > 0 ? sb.pop_front() : '0;
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
            chk("bp_hold_sum", 32'(rsp_sum), 32'(e.sum));
            chk("bp_hold_id", 32'(rsp_id), 32'(e.id));
            chk("bp_hold_ready", 32'(req_ready), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_release_valid", 32'(rsp_valid), 32'd0);
        chk("bp_regrant", 32'(req_ready), 32'b0010);
        run_op(4'b0010, 1, "bp2");

        // Reset while a response is pending: it must vanish.
        load(3, 16'hAAAA, 16'h5555, 1'b1);
        rsp_ready = 1'b0;
        req_valid = 4'b1000;
        #1;
        chk("rr_grant", 32'(req_ready), 32'b1000);
        step();
        req_valid = '0;
        step();
        chk("rr_valid", 32'(rsp_valid), 32'd1);
        chk("rr_sum", 32'(rsp_sum), 32'h0000);
        chk("rr_cout", 32'(rsp_cout), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rr_async_valid", 32'(rsp_valid), 32'd0);
        chk("rr_async_sum", 32'(rsp_sum), 32'd0);
        step();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("rr_no_rsp", 32'(rsp_valid), 32'd0);
        load(1, 16'h0101, 16'h2020, 1'b1);
        load(3, 16'h3333, 16'h4444, 1'b0);
        run_op(4'b1010, 1, "post_rst");

        // Fresh pointer, then a request that disappears before the clock edge.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        req_valid = 4'b0100;
        #1;
        chk("drop_comb_ready", 32'(req_ready), 32'b0100);
        #1;
        req_valid = '0;
        for (int i = 0; i < 3; i++) step();
        chk("drop_no_rsp", 32'(rsp_valid), 32'd0);

        load(0, 16'h1111, 16'h0001, 1'b0);
        load(1, 16'h2222, 16'h0002, 1'b1);
        load(2, 16'h8000, 16'h8000, 1'b0);
        load(3, 16'h7FFF, 16'h0001, 1'b1);
        for (int k = 0; k < 5; k++) begin
`ifdef KS_ARB_FIXED_PRIO_EN
            exp_g = 0;
`else
            exp_g = k % 4;
`endif
            run_op(4'b1111, exp_g, $sformatf("cont%0d", k));
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ks_adder_arbiter.md
KS_ADDER_ARBITER -- requirements
Module: ks_adder_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the adder (2..8).
REQ-002 Parameter ID_W, default 2, width of requester index; SHALL equal clog2(N_REQ).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  N_REQ  per-requester operation request.
REQ-006 req_ready  output  N_REQ  one-hot grant; transfer when req_valid[i] & req_ready[i].
REQ-007 req_a  input  16*N_REQ  operand A; slice i belongs to requester i.
REQ-008 req_b  input  16*N_REQ  operand B; slice i belongs to requester i.
REQ-009 req_cin  input  N_REQ  carry-in per requester.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_ready  input  1  consumer accepts result when rsp_valid & rsp_ready.
REQ-012 rsp_id  output  ID_W  index of requester that owns the result.
REQ-013 rsp_sum  output  16  sum bits.
REQ-014 rsp_cout  output  1  carry-out.

Function
REQ-015 FSM states SHALL be IDLE, ADD, RESP; exactly one operation in flight at any time.
REQ-016 IDLE: if any req_valid bit is set, assert req_ready for the winner only (combinational, same cycle), register its A, B, Cin, id; go to ADD.
REQ-017 IDLE with no req_valid: stay in IDLE; req_ready all zero.
REQ-018 Arbitration: round-robin; search starts at rr_ptr, wraps N_REQ-1 -> 0.
REQ-019 ADD: registered operands drive the shared adder; {cout,sum} = A + B + Cin, 17-bit result, sum = low 16 bits, modulo 2^16; capture into the result registers; go to RESP.
REQ-020 RESP: rsp_valid = 1, rsp_id/rsp_sum/rsp_cout stable until handshake.
REQ-021 RESP with rsp_ready = 1: rsp_valid deasserts next cycle, rr_ptr <= (id+1) mod N_REQ, go to IDLE.
REQ-022 RESP with rsp_ready = 0: stall indefinitely; req_ready stays all zero.
REQ-023 Latency: grant at cycle T, rsp_valid high at T+2; peak throughput one operation per 3 cycles.
REQ-024 req_valid dropped before grant: no grant, no operation, rr_ptr unchanged.
REQ-025 Operands/Cin changing after grant SHALL NOT affect the in-flight result.
REQ-026 req_ready SHALL be zero in ADD and RESP regardless of req_valid.

Reset
REQ-027 rst_n low: state = IDLE, rr_ptr = 0, rsp_valid = 0, rsp_id = 0, rsp_sum = 0, rsp_cout = 0, operand registers = 0, req_ready = 0.
REQ-028 Reset mid-operation (ADD or RESP) SHALL discard the in-flight operation with no response.

Configuration
REQ-029 Macro KS_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins; rr_ptr not implemented.
REQ-030 Macro absent: round-robin per REQ-018/REQ-021.

Structure
REQ-031 Package ks_arb_pkg SHALL hold DATA_W = 16, the state enum, and the reset value constants.
REQ-032 One sub-module: the existing KS_Adder_16bit, instantiated once as the shared datapath; no other adder logic.

Verification
REQ-033 Single req: req 0, A=1234, B=5678, Cin=0 -> rsp at T+2: sum 68AC, cout 0, id 0.
REQ-034 Overflow: req 2, A=FFFF, B=FFFF, Cin=1 -> sum FFFF, cout 1, id 2; A=FFFF, B=0001, Cin=0 -> sum 0000, cout 1.
REQ-035 Contention: all 4 valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; with KS_ARB_FIXED_PRIO_EN -> always 0.
REQ-036 Backpressure: rsp_ready=0 for 10 cycles with req 1 valid -> rsp held stable, req_ready all 0; on release -> req 1 granted next IDLE.
REQ-037 Reset in RESP: A=AAAA, B=5555, Cin=1 pending, rst_n pulsed low -> rsp_valid 0, no response, next grant goes to lowest valid index.
